regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised successor to the fixed 2R1W regfile: N-read/1-write register file with per-register pending-write counters.
//  Sits beside OF (read ports, issue port) and WB (write port) of the 5-stage CPU; OF stalls on Hazard_o.
//  Supports multiple in-flight writes to one register (WAW), optional WB->OF bypass and an optional hard-zero r0.
// PARAMETERS
//  WIDTH       32  data width of each register
//  DEPTH       16  number of architectural registers; AW = $clog2(DEPTH)
//  NUM_RD      2   number of combinational read ports
//  MAX_PEND    3   max in-flight writes per register; CW = $clog2(MAX_PEND+1)
//  BYPASS      1   1: a read of a register whose last pending write retires this cycle returns Wb_Data_i, not busy
//  R0_ZERO     0   1: register 0 reads 0, is never busy, ignores writes and issues
// PORTS
//  Clk           in   1             clock, all state on rising edge
//  Rst           in   1             synchronous reset, active high
//  Rd_Addr_i     in   NUM_RD*AW     read addresses, port i at [i*AW +: AW]
//  Rd_Data_o     out  NUM_RD*WIDTH  read data, combinational
//  Rd_Busy_o     out  NUM_RD        port i's register has an unresolved pending write
//  Hazard_o      out  1             OR of Rd_Busy_o over ports with Rd_Use_i set
//  Rd_Use_i      in   NUM_RD        port i is a real source operand this cycle
//  Iss_En_i      in   1             OF->EX handshake fired this cycle
//  Iss_Wr_i      in   1             issued instruction writes a register
//  Iss_Dst_i     in   AW            destination of issued instruction
//  Iss_Full_o    out  1             count[Iss_Dst_i]==MAX_PEND; OF must not issue
//  Wb_En_i       in   1             WB write strobe
//  Wb_Addr_i     in   AW            WB destination
//  Wb_Data_i     in   WIDTH         WB data
//  Err_o         out  1             sticky: underflow (WB to count 0) or overflow (issue while full)
// BEHAVIOUR
//  - Reset (Clk edge with Rst=1): all registers 0, all counts 0, Err_o 0. Reset wins over every same-cycle input.
//  - Outputs after reset: Rd_Data_o 0, Rd_Busy_o 0, Hazard_o 0, Iss_Full_o 0.
//  - Write: Wb_En_i -> reg[Wb_Addr_i] <= Wb_Data_i at the next edge, 1-cycle latency; visible on reads the following cycle.
//  - Count update per register r, with inc = Iss_En_i&Iss_Wr_i&(Iss_Dst_i==r) and dec = Wb_En_i&(Wb_Addr_i==r):
//      inc&!dec -> +1; dec&!inc -> -1; both -> unchanged; neither -> unchanged.
//  - Underflow: dec with count 0 -> data still written, count stays 0, Err_o<=1.
//  - Overflow: inc with count MAX_PEND and no dec -> count stays MAX_PEND, Err_o<=1. Inc with simultaneous dec is legal even when full.
//  - Iss_Full_o is combinational from Iss_Dst_i. It ignores a same-cycle dec, so the check is conservative.
//  - Read port i, with a = Rd_Addr_i[i] and byp = BYPASS & Wb_En_i & (Wb_Addr_i==a) & (count[a]==1):
//      Rd_Data_o[i] = byp ? Wb_Data_i : reg[a];  Rd_Busy_o[i] = (count[a]!=0) & !byp.
//    With count>1 there is no bypass; the port stays busy until the youngest write retires.
//  - Same-cycle issue to a register being read: the read is evaluated on pre-edge counts, with no self-hazard.
//  - R0_ZERO=1, a==0: data 0, busy 0. Writes and issues to r0 change nothing and never set Err_o.
//  - Flush is handled upstream: branches resolve in EX and only squash IF/OF, so no squashed instruction has issued and counts are never rolled back.
//  - Reset mid-operation clears all pending counts. A stale WB after reset writes data and sets Err_o via underflow.
// STRUCTURE
//  - cpu_pkg additions: REG_ADDR_WIDTH, RF_MAX_PEND, typedef rf_wb_t {en, addr, data}, typedef rf_iss_t {en, wr, dst}.
//  - Sub-module sb_pend_cnt (one per register): saturating up/down CW-bit counter with inc/dec/full/err outputs.
//  - Top: storage array, DEPTH x sb_pend_cnt generate loop, NUM_RD read/bypass mux generate loop, Err_o OR-reduce.
// TESTING
//  1. Reset then read r3, r7 with Rd_Use_i=11 -> data 0/0, busy 00, Hazard_o 0, Err_o 0.
//  2. Issue dst r5; next cycle read r5 -> busy 1, Hazard_o 1; WB r5=0xDEADBEEF with BYPASS=1 -> same cycle data 0xDEADBEEF, busy 0.
//  3. Issue r4 twice, WB r4=0x11 -> count 1, read still busy; WB r4=0x22 -> bypass 0x22; next cycle reg 0x22, busy 0.
//  4. Issue r2 three times (MAX_PEND=3) -> Iss_Full_o 1; issue again with no WB -> Err_o 1, count 3; issue+WB same cycle -> count 3, no new error.
//  5. WB r9 with count 0 -> reg 0x… written, Err_o 1 sticky; Rst pulse -> Err_o 0, all counts 0.
//  6. R0_ZERO=1: issue r0 plus WB r0=0xFF -> read r0 returns 0, busy 0, Err_o 0; BYPASS=0: WB r5 count 1 -> busy 1 that cycle, 0 next.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// The structs bundle the WB and issue sideband for callers built at the
// default data and address widths.
package regfile_scoreboard_pkg;

    localparam int REG_ADDR_WIDTH = 4;
    localparam int RF_DATA_WIDTH  = 32;
    localparam int RF_MAX_PEND    = 3;

    // Write-back port bundle.
    typedef struct packed {
        logic                      en;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0]  data;
    } rf_wb_t;

    // Issue port bundle.
    typedef struct packed {
        logic                      en;
        logic                      wr;
        logic [REG_ADDR_WIDTH-1:0] dst;
    } rf_iss_t;

    // Returns the counter width needed to hold 0..max_pend.
    function automatic int rf_cnt_width(input int max_pend);
        return (max_pend < 1) ? 1 : $clog2(max_pend + 1);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_pend_cnt.sv
// Per-register pending-write counter.
// An increment is an issued write to this register and a decrement is a
// WB retirement. The count saturates at both ends, and the err_o pulse
// reports an underflow or an overflow.
module sb_pend_cnt
    import regfile_scoreboard_pkg::*;
#(
    parameter int MAX_PEND = RF_MAX_PEND,
    parameter int CW       = rf_cnt_width(MAX_PEND)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          err_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          full_s;
    logic          err_s;

    assign full_s = (cnt_q == CW'(MAX_PEND));

    // Next count. Saturate instead of wrapping, and flag the illegal event.
    always_comb begin
        cnt_d = cnt_q;
        err_s = 1'b0;
        case ({inc_i, dec_i})
            2'b10: begin
                if (full_s) begin
                    err_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            2'b01: begin
                if (cnt_q == '0) begin
                    err_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            2'b11: begin
                // Issue and retire cancel out. Retiring from zero is still an underflow.
                if (cnt_q == '0) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = full_s;
    assign err_o  = err_s;

endmodule

// File: rtl/regfile_scoreboard.sv
// N-read / 1-write register file with per-register pending-write counters.
// OF uses Rd_Busy_o and Hazard_o to stall, and Iss_Full_o to hold off an
// issue. WB retires the writes. A final WB can be bypassed to a read in the
// same cycle.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int  WIDTH    = RF_DATA_WIDTH,
    parameter int  DEPTH    = 16,
    parameter int  NUM_RD   = 2,
    parameter int  MAX_PEND = RF_MAX_PEND,
    parameter int  BYPASS   = 1,
    parameter int  R0_ZERO  = 0,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW       = rf_cnt_width(MAX_PEND)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_RD*AW-1:0]    Rd_Addr_i,
    output logic [NUM_RD*WIDTH-1:0] Rd_Data_o,
    output logic [NUM_RD-1:0]       Rd_Busy_o,
    output logic                    Hazard_o,
    input  logic [NUM_RD-1:0]       Rd_Use_i,
    input  logic                    Iss_En_i,
    input  logic                    Iss_Wr_i,
    input  logic [AW-1:0]           Iss_Dst_i,
    output logic                    Iss_Full_o,
    input  logic                    Wb_En_i,
    input  logic [AW-1:0]           Wb_Addr_i,
    input  logic [WIDTH-1:0]        Wb_Data_i,
    output logic                    Err_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    cnt_s [DEPTH];
    logic [DEPTH-1:0] inc_s;
    logic [DEPTH-1:0] dec_s;
    logic [DEPTH-1:0] full_s;
    logic [DEPTH-1:0] cnt_err_s;
    logic             err_q;
    logic             err_d;
    logic             iss_full_s;

    // An address maps to a real register. This matters only when DEPTH is not a power of two.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(DEPTH));
    endfunction

    // Per-register decode and pending-write counter.
    // A hard-zero r0 never sees an issue or a retirement.
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        localparam bit LOCKED = (R0_ZERO != 0) && (r == 0);

        assign inc_s[r] = !LOCKED && Iss_En_i && Iss_Wr_i && (Iss_Dst_i == AW'(r));
        assign dec_s[r] = !LOCKED && Wb_En_i && (Wb_Addr_i == AW'(r));

        sb_pend_cnt #(
            .MAX_PEND (MAX_PEND),
            .CW       (CW)
        ) u_cnt (
            .clk_i  (Clk),
            .rst_i  (Rst),
            .inc_i  (inc_s[r]),
            .dec_i  (dec_s[r]),
            .cnt_o  (cnt_s[r]),
            .full_o (full_s[r]),
            .err_o  (cnt_err_s[r])
        );
    end

    // Register storage. A WB always writes its data, even when the count underflows.
    always_ff @(posedge Clk) begin
        for (int r = 0; r < DEPTH; r++) begin
            if (Rst) begin
                mem_q[r] <= '0;
            end else if (dec_s[r]) begin
                mem_q[r] <= Wb_Data_i;
            end else begin
                mem_q[r] <= mem_q[r];
            end
        end
    end

    // Read ports. A read returns Wb_Data_i only when this WB is the last outstanding write.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    addr_s;
        logic [WIDTH-1:0] data_s;
        logic             busy_s;
        logic             byp_s;

        assign addr_s = Rd_Addr_i[p*AW +: AW];

        // Read port p: select the bypass or stored data, and the busy flag.
        always_comb begin
            data_s = '0;
            busy_s = 1'b0;
            byp_s  = 1'b0;
            if (addr_ok(addr_s) && !((R0_ZERO != 0) && (addr_s == '0))) begin
                byp_s  = (BYPASS != 0) && Wb_En_i && (Wb_Addr_i == addr_s)
                         && (cnt_s[addr_s] == CW'(1));
                busy_s = (cnt_s[addr_s] != '0) && !byp_s;
                if (byp_s) begin
                    data_s = Wb_Data_i;
                end else begin
                    data_s = mem_q[addr_s];
                end
            end else begin
                data_s = '0;
                busy_s = 1'b0;
            end
        end

        assign Rd_Data_o[p*WIDTH +: WIDTH] = data_s;
        assign Rd_Busy_o[p]                = busy_s;
    end

    assign Hazard_o = |(Rd_Busy_o & Rd_Use_i);

    // Issue-full check on the pre-edge count. A same-cycle retirement is ignored, so the check is conservative.
    always_comb begin
        iss_full_s = 1'b0;
        if (addr_ok(Iss_Dst_i)) begin
            iss_full_s = full_s[Iss_Dst_i];
        end else begin
            iss_full_s = 1'b0;
        end
    end

    assign Iss_Full_o = iss_full_s;

    // Next value of the sticky error flag: any counter event latches it until reset.
    always_comb begin
        err_d = err_q | (|cnt_err_s);
    end

    // Sticky error register. Only reset clears it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Err_o = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard.
// The table drives a BYPASS=1 instance one row per cycle. A hand-written
// sequence then checks a second instance with R0_ZERO=1 and BYPASS=0.
module tb_regfile_scoreboard;

    typedef struct {
        logic        rst;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [1:0]  usem;
        logic        ie;
        logic        iw;
        logic [3:0]  dst;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        haz;
        logic        full;
        logic        err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [1:0]  rd_use;
    logic        iss_en;
    logic        iss_wr;
    logic [3:0]  iss_dst;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        hazard;
    logic        iss_full;
    logic        err;

    logic [63:0] rd_data2;
    logic [1:0]  rd_busy2;
    logic        hazard2;
    logic        iss_full2;
    logic        err2;

    int n_vec;
    int n_miss;
    vec_t tbl[$];

    regfile_scoreboard #(
        .WIDTH(32), .DEPTH(16), .NUM_RD(2), .MAX_PEND(3), .BYPASS(1), .R0_ZERO(0)
    ) dut (
        .Clk(clk), .Rst(rst), .Rd_Addr_i(rd_addr), .Rd_Data_o(rd_data),
        .Rd_Busy_o(rd_busy), .Hazard_o(hazard), .Rd_Use_i(rd_use),
        .Iss_En_i(iss_en), .Iss_Wr_i(iss_wr), .Iss_Dst_i(iss_dst),
        .Iss_Full_o(iss_full), .Wb_En_i(wb_en), .Wb_Addr_i(wb_addr),
        .Wb_Data_i(wb_data), .Err_o(err)
    );

    regfile_scoreboard #(
        .WIDTH(32), .DEPTH(16), .NUM_RD(2), .MAX_PEND(3), .BYPASS(0), .R0_ZERO(1)
    ) dut2 (
        .Clk(clk), .Rst(rst), .Rd_Addr_i(rd_addr), .Rd_Data_o(rd_data2),
        .Rd_Busy_o(rd_busy2), .Hazard_o(hazard2), .Rd_Use_i(rd_use),
        .Iss_En_i(iss_en), .Iss_Wr_i(iss_wr), .Iss_Dst_i(iss_dst),
        .Iss_Full_o(iss_full2), .Wb_En_i(wb_en), .Wb_Addr_i(wb_addr),
        .Wb_Data_i(wb_data), .Err_o(err2)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic rst_v, input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] usem,
        input logic ie, input logic iw, input logic [3:0] dst,
        input logic we, input logic [3:0] wa, input logic [31:0] wd,
        input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] busy,
        input logic haz, input logic full, input logic errv);
        vec_t v;
        v.rst = rst_v; v.a0 = a0; v.a1 = a1; v.usem = usem;
        v.ie = ie; v.iw = iw; v.dst = dst;
        v.we = we; v.wa = wa; v.wd = wd;
        v.d0 = d0; v.d1 = d1; v.busy = busy; v.haz = haz; v.full = full; v.err = errv;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst     = v.rst;
        rd_addr = {v.a1, v.a0};
        rd_use  = v.usem;
        iss_en  = v.ie;
        iss_wr  = v.iw;
        iss_dst = v.dst;
        wb_en   = v.we;
        wb_addr = v.wa;
        wb_data = v.wd;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        vec_t idle;
        n_vec  = 0;
        n_miss = 0;
        idle = mk(1'b0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,
                  32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);

        // rst a0 a1 use | ie iw dst | we wa wd | d0 d1 busy haz full err
        // Reset state, then read r3 and r7.
        tbl.push_back(mk(1'b0, 4'd3, 4'd7, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        // Issue r5 (no self-hazard), then r5 busy, then final WB is bypassed.
        tbl.push_back(mk(1'b0, 4'd5, 4'd0, 2'b01, 1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd5, 4'd0, 2'b01, 1'b0, 1'b0, 4'd5, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd5, 4'd0, 2'b01, 1'b0, 1'b0, 4'd5, 1'b1, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd5, 4'd0, 2'b01, 1'b0, 1'b0, 4'd5, 1'b0, 4'd0, 32'h0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        // WAW on r4: the first WB gets no bypass, the second does.
        tbl.push_back(mk(1'b0, 4'd4, 4'd4, 2'b01, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd4, 4'd4, 2'b01, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd4, 4'd4, 2'b01, 1'b0, 1'b0, 4'd4, 1'b1, 4'd4, 32'h11, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd4, 4'd4, 2'b11, 1'b0, 1'b0, 4'd4, 1'b1, 4'd4, 32'h22, 32'h22, 32'h22, 2'b00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd4, 4'd4, 2'b11, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 32'h0, 32'h22, 32'h22, 2'b00, 1'b0, 1'b0, 1'b0));
        // Fill r2 to MAX_PEND, overflow, then issue and WB together while full.
        tbl.push_back(mk(1'b0, 4'd2, 4'd4, 2'b01, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 32'h0, 32'h22, 2'b00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd2, 4'd4, 2'b01, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 32'h0, 32'h22, 2'b01, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd2, 4'd4, 2'b01, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 32'h0, 32'h22, 2'b01, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd2, 4'd4, 2'b01, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0, 32'h0, 32'h0, 32'h22, 2'b01, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'd2, 4'd4, 2'b01, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 32'h0, 32'h22, 2'b01, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'd2, 4'd4, 2'b01, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0, 32'h0, 32'h0, 32'h22, 2'b01, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 4'd2, 4'd4, 2'b01, 1'b1, 1'b1, 4'd2, 1'b1, 4'd2, 32'h33, 32'h0, 32'h22, 2'b01, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 4'd2, 4'd4, 2'b01, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0, 32'h0, 32'h33, 32'h22, 2'b01, 1'b1, 1'b1, 1'b1));
        // Reset clears data, counts and Err_o.
        tbl.push_back(mk(1'b1, 4'd2, 4'd4, 2'b01, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0, 32'h0, 32'h33, 32'h22, 2'b01, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 4'd2, 4'd9, 2'b11, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        // Underflow on r9: data is written and Err_o stays set.
        tbl.push_back(mk(1'b0, 4'd2, 4'd9, 2'b10, 1'b0, 1'b0, 4'd2, 1'b1, 4'd9, 32'h99, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd2, 4'd9, 2'b10, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0, 32'h0, 32'h0, 32'h99, 2'b00, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'd2, 4'd9, 2'b10, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0, 32'h0, 32'h0, 32'h99, 2'b00, 1'b0, 1'b0, 1'b1));
        // Reset wins over a same-cycle issue and WB to r6. A stale WB then underflows.
        tbl.push_back(mk(1'b1, 4'd6, 4'd9, 2'b11, 1'b1, 1'b1, 4'd6, 1'b1, 4'd6, 32'h66, 32'h0, 32'h99, 2'b00, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'd6, 4'd9, 2'b11, 1'b0, 1'b0, 4'd6, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd6, 4'd9, 2'b11, 1'b0, 1'b0, 4'd6, 1'b1, 4'd6, 32'h77, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'd6, 4'd9, 2'b11, 1'b0, 1'b0, 4'd6, 1'b0, 4'd0, 32'h0, 32'h77, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1));

        // Initial reset: two cycles.
        idle.rst = 1'b1;
        drive(idle);
        @(negedge clk);
        @(negedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d.d0", i), rd_data[31:0], tbl[i].d0);
            chk($sformatf("v%0d.d1", i), rd_data[63:32], tbl[i].d1);
            chk($sformatf("v%0d.busy", i), {30'd0, rd_busy}, {30'd0, tbl[i].busy});
            chk($sformatf("v%0d.haz", i), {31'd0, hazard}, {31'd0, tbl[i].haz});
            chk($sformatf("v%0d.full", i), {31'd0, iss_full}, {31'd0, tbl[i].full});
            chk($sformatf("v%0d.err", i), {31'd0, err}, {31'd0, tbl[i].err});
        end

        // Second instance, R0_ZERO=1 and BYPASS=0: start from reset.
        @(negedge clk);
        idle.rst = 1'b1;
        drive(idle);
        idle.rst = 1'b0;

        // Issue r0 and WB r0 in the same cycle: both are ignored.
        @(negedge clk);
        drive(mk(1'b0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 32'hFF, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        #1;
        chk("r0.d0", rd_data2[31:0], 32'h0);
        chk("r0.busy", {30'd0, rd_busy2}, 32'h0);
        chk("r0.full", {31'd0, iss_full2}, 32'h0);
        chk("r0.err", {31'd0, err2}, 32'h0);

        // A lone WB to r0 must not underflow.
        @(negedge clk);
        drive(mk(1'b0, 4'd0, 4'd0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 32'hAA, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        #1;
        chk("r0.d0_after_wb", rd_data2[31:0], 32'h0);
        chk("r0.busy_after_iss", {30'd0, rd_busy2}, 32'h0);

        // Issue r5 and confirm that no error came from r0.
        @(negedge clk);
        drive(mk(1'b0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        #1;
        chk("r0.d0_late", rd_data2[31:0], 32'h0);
        chk("r0.err_late", {31'd0, err2}, 32'h0);

        @(negedge clk);
        drive(mk(1'b0, 4'd5, 4'd0, 2'b01, 1'b0, 1'b0, 4'd5, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        #1;
        chk("nb.busy_pend", {30'd0, rd_busy2}, 32'h1);
        chk("nb.haz_pend", {31'd0, hazard2}, 32'h1);

        // Without bypass, the final WB still leaves the read busy in that cycle.
        @(negedge clk);
        drive(mk(1'b0, 4'd5, 4'd0, 2'b01, 1'b0, 1'b0, 4'd5, 1'b1, 4'd5, 32'h55, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        #1;
        chk("nb.busy_wb", {30'd0, rd_busy2}, 32'h1);
        chk("nb.d0_wb", rd_data2[31:0], 32'h0);
        chk("nb.haz_wb", {31'd0, hazard2}, 32'h1);

        @(negedge clk);
        drive(mk(1'b0, 4'd5, 4'd0, 2'b01, 1'b0, 1'b0, 4'd5, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        #1;
        chk("nb.d0_next", rd_data2[31:0], 32'h55);
        chk("nb.busy_next", {30'd0, rd_busy2}, 32'h0);
        chk("nb.haz_next", {31'd0, hazard2}, 32'h0);
        chk("nb.err_next", {31'd0, err2}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
